// File: rtl/fwd_pkg.sv
// Shared encodings for the fwd_scoreboard forwarding unit: register classes, select codes
// and the record tracked for each in-flight destination write.
package fwd_pkg;

    localparam logic [1:0] CLS_PRED = 2'd0;
    localparam logic [1:0] CLS_INT  = 2'd1;
    localparam logic [1:0] CLS_FP   = 2'd2;

    localparam int SEL_REG = 0;

    // Entries hold register numbers at this width; smaller register files zero-extend.
    localparam int FWD_MAX_REG_W = 8;

    typedef struct packed {
        logic                     valid;
        logic [FWD_MAX_REG_W-1:0] dst_reg;
        logic [1:0]               dst_cls;
        logic                     is_load;
    } fwd_entry_t;

    function automatic int sel_imm(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source comparator: matches one source operand against every tracked entry and
// priority-encodes the youngest producer into a forward select plus a load-use flag.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = 3
) (
    input  fwd_entry_t [DEPTH-1:0]    i_entries,
    input  logic [FWD_MAX_REG_W-1:0]  i_src_reg,
    input  logic [1:0]                i_src_cls,
    input  logic                      i_src_ovr,
    output logic [SEL_W-1:0]          o_sel,
    output logic                      o_load_hazard
);

    logic             w_zero_reg;
    logic [DEPTH-1:0] w_match;

    assign w_zero_reg = (i_src_cls == CLS_INT) && (i_src_reg == '0);

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign w_match[g] = i_entries[g].valid
                         && (i_entries[g].dst_reg == i_src_reg)
                         && (i_entries[g].dst_cls == i_src_cls)
                         && !i_src_ovr
                         && !w_zero_reg;
    end

    // Array index g is stage g+1; scanning oldest to youngest leaves the youngest match.
    always_comb begin
        o_sel         = SEL_W'(SEL_REG);
        o_load_hazard = 1'b0;
        if (i_src_ovr) begin
            o_sel = SEL_W'(sel_imm(DEPTH));
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_match[i]) begin
                    o_sel = SEL_W'(i + 1);
                end
            end
        end
        for (int i = 0; i < LOAD_LAT - 1; i++) begin
            if (w_match[i] && i_entries[i].is_load) begin
                o_load_hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit tracking DEPTH in-flight writes after ID.
// Optional performance counters are built when FWD_PERF_CNT_EN is defined.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int  NUM_REGS = 16,
    parameter int  NUM_SRC  = 3,
    parameter int  DEPTH    = 3,
    parameter int  LOAD_LAT = 2,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int SEL_W    = $clog2(DEPTH + 2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_W-1:0]   id_src_reg,
    input  logic [NUM_SRC*2-1:0]       id_src_cls,
    input  logic [NUM_SRC-1:0]         id_src_ovr,
    input  logic [REG_W-1:0]           id_dst_reg,
    input  logic [1:0]                 id_dst_cls,
    input  logic                       id_dst_we,
    input  logic                       id_is_load,
    output logic                       stall,
    output logic                       ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                perf_stall_cyc,
    output logic [31:0]                perf_fwd_cnt
`endif
);

    fwd_entry_t [DEPTH-1:0]     r_entries;
    fwd_entry_t                 w_id_entry;
    logic [NUM_SRC-1:0]         w_hazard;
    logic [NUM_SRC*SEL_W-1:0]   w_sel;
    logic                       w_issue;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [FWD_MAX_REG_W-1:0] w_src_reg;
        assign w_src_reg = FWD_MAX_REG_W'(id_src_reg[s*REG_W +: REG_W]);

        fwd_match #(
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_match (
            .i_entries     (r_entries),
            .i_src_reg     (w_src_reg),
            .i_src_cls     (id_src_cls[s*2 +: 2]),
            .i_src_ovr     (id_src_ovr[s]),
            .o_sel         (w_sel[s*SEL_W +: SEL_W]),
            .o_load_hazard (w_hazard[s])
        );
    end

    assign stall   = id_valid && !flush && (|w_hazard);
    assign w_issue = id_valid && !stall && !flush;

    // A non-issuing cycle still shifts, leaving a bubble in stage 1.
    always_comb begin
        w_id_entry         = '0;
        w_id_entry.valid   = w_issue && id_dst_we;
        w_id_entry.dst_reg = FWD_MAX_REG_W'(id_dst_reg);
        w_id_entry.dst_cls = id_dst_cls;
        w_id_entry.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entries  <= '0;
            ex_valid   <= 1'b0;
            ex_fwd_sel <= '0;
        end else if (flush) begin
            r_entries  <= '0;
            ex_valid   <= 1'b0;
            ex_fwd_sel <= '0;
        end else begin
            r_entries  <= {r_entries[DEPTH-2:0], w_id_entry};
            ex_valid   <= w_issue;
            ex_fwd_sel <= w_issue ? w_sel : '0;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] w_fwd_inc;

    // Only selects that name a pipeline latch count as forwards; regfile and imm do not.
    always_comb begin
        w_fwd_inc = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_issue && (w_sel[s*SEL_W +: SEL_W] != '0)
                        && (w_sel[s*SEL_W +: SEL_W] <= SEL_W'(DEPTH))) begin
                w_fwd_inc = w_fwd_inc + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            perf_stall_cyc <= perf_stall_cyc + {31'd0, stall};
            perf_fwd_cnt   <= perf_fwd_cnt + w_fwd_inc;
        end
    end
`endif

endmodule
